// File: rtl/csr_defs.sv
// Shared CSR layout constants for the multi-channel timer block: per-channel
// register offsets, channel stride and TCFG/TICLR field positions.
package csr_defs;

    localparam int unsigned CH_STRIDE      = 32'd4;
    localparam int unsigned TCFG_OFS       = 32'd0;
    localparam int unsigned TVAL_OFS       = 32'd1;
    localparam int unsigned TICLR_OFS      = 32'd3;

    localparam int unsigned LTCFG_EN       = 32'd0;
    localparam int unsigned LTCFG_PERIODIC = 32'd1;
    localparam int unsigned LTCFG_INITVAL  = 32'd2;
    localparam int unsigned LTICLR_CLR     = 32'd0;

    // Bitwise masked merge used by every CSR write: masked bits take wdata.
    function automatic logic [31:0] masked_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [31:0] mask_v
    );
        return (old_v & ~mask_v) | (new_v & mask_v);
    endfunction

endpackage

// File: rtl/c7bcsr_tchan.sv
// One timer channel: TCFG fields, down-counter, armed flag, sticky pending bit
// and the channel's share of the CSR read mux.
module c7bcsr_tchan
    import csr_defs::*;
#(
    parameter int TIMER_BIT = 30
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        tick,
    input  logic        tcfg_we,
    input  logic        ticlr_we,
    input  logic [31:0] wdata,
    input  logic [31:0] mask,
    input  logic        rd_tcfg,
    input  logic        rd_tval,
    output logic [31:0] rdata,
    output logic        pending
);

    localparam logic [TIMER_BIT-1:0] CNT_ONE = TIMER_BIT'(1'b1);

    logic                 en_r, en_n_s;
    logic                 periodic_r, periodic_n_s;
    logic [TIMER_BIT-1:0] initval_r, initval_n_s;
    logic [TIMER_BIT-1:0] cnt_r, cnt_n_s;
    logic                 armed_r, armed_n_s;
    logic                 pending_r, pending_n_s;
    logic                 fire_s;
    logic [31:0]          tcfg_cur_s;
    logic [31:0]          tcfg_new_s;

    // Current TCFG image and its masked-merge with the incoming write.
    always_comb begin
        tcfg_cur_s                               = 32'd0;
        tcfg_cur_s[LTCFG_EN]                     = en_r;
        tcfg_cur_s[LTCFG_PERIODIC]               = periodic_r;
        tcfg_cur_s[LTCFG_INITVAL +: TIMER_BIT]   = initval_r;
        tcfg_new_s = masked_merge(tcfg_cur_s, wdata, mask);
    end

    // Next-state: a TCFG write preempts the tick; a fire beats a TICLR clear.
    always_comb begin
        en_n_s       = en_r;
        periodic_n_s = periodic_r;
        initval_n_s  = initval_r;
        cnt_n_s      = cnt_r;
        armed_n_s    = armed_r;
        fire_s       = 1'b0;
        if (tcfg_we) begin
            en_n_s       = tcfg_new_s[LTCFG_EN];
            periodic_n_s = tcfg_new_s[LTCFG_PERIODIC];
            initval_n_s  = tcfg_new_s[LTCFG_INITVAL +: TIMER_BIT];
            cnt_n_s      = tcfg_new_s[LTCFG_INITVAL +: TIMER_BIT];
            armed_n_s    = 1'b1;
        end else if (tick && en_r) begin
            if (cnt_r != '0) begin
                cnt_n_s = cnt_r - CNT_ONE;
            end else if (armed_r) begin
                fire_s = 1'b1;
                if (periodic_r) begin
                    cnt_n_s = initval_r;
                end else begin
                    armed_n_s = 1'b0;
                end
            end else begin
                cnt_n_s = cnt_r;
            end
        end else begin
            cnt_n_s = cnt_r;
        end

        if (fire_s) begin
            pending_n_s = 1'b1;
        end else if (ticlr_we && wdata[LTICLR_CLR] && mask[LTICLR_CLR]) begin
            pending_n_s = 1'b0;
        end else begin
            pending_n_s = pending_r;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            en_r       <= 1'b0;
            periodic_r <= 1'b0;
            initval_r  <= '0;
            cnt_r      <= '0;
            armed_r    <= 1'b0;
            pending_r  <= 1'b0;
        end else begin
            en_r       <= en_n_s;
            periodic_r <= periodic_n_s;
            initval_r  <= initval_n_s;
            cnt_r      <= cnt_n_s;
            armed_r    <= armed_n_s;
            pending_r  <= pending_n_s;
        end
    end

    // Read mux; TICLR and unmapped offsets read as zero.
    always_comb begin
        if (rd_tcfg) begin
            rdata = tcfg_cur_s;
        end else if (rd_tval) begin
            rdata = {{(32 - TIMER_BIT){1'b0}}, cnt_r};
        end else begin
            rdata = 32'd0;
        end
    end

    assign pending = pending_r;

endmodule

// File: rtl/c7bcsr_mtimer.sv
// Multi-channel CSR timer: shared prescaler, per-channel address decode and
// an OR-reduced combinational read port; interrupt vector comes from registers.
module c7bcsr_mtimer
    import csr_defs::*;
#(
    parameter int                  NCH       = 4,
    parameter int                  TIMER_BIT = 30,
    parameter int                  PRESCALE  = 1,
    parameter int                  LCSR_BIT  = 14,
    parameter logic [LCSR_BIT-1:0] ADDR_BASE = 14'h41
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [LCSR_BIT-1:0] csr_waddr,
    input  logic [31:0]         csr_wdata,
    input  logic [31:0]         csr_mask,
    input  logic                csr_wen,
    input  logic [LCSR_BIT-1:0] csr_raddr,
    output logic [31:0]         csr_rdata,
    output logic [NCH-1:0]      timer_intr_vec,
    output logic                timer_intr
);

    logic              tick_s;
    logic [NCH-1:0]    pending_s;
    logic [31:0]       ch_rdata_s [NCH];

    if (PRESCALE == 32'd1) begin : g_ps_bypass
        assign tick_s = 1'b1;
    end else begin : g_ps
        localparam int PS_W = $clog2(PRESCALE);
        localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 32'd1);
        logic [PS_W-1:0] ps_cnt_r;

        // Free-running prescaler; CSR traffic never disturbs its phase.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                ps_cnt_r <= '0;
            end else if (ps_cnt_r == PS_MAX) begin
                ps_cnt_r <= '0;
            end else begin
                ps_cnt_r <= ps_cnt_r + PS_W'(1'b1);
            end
        end

        assign tick_s = (ps_cnt_r == PS_MAX);
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam logic [LCSR_BIT-1:0] A_TCFG  = ADDR_BASE + LCSR_BIT'(CH_STRIDE * i + TCFG_OFS);
        localparam logic [LCSR_BIT-1:0] A_TVAL  = ADDR_BASE + LCSR_BIT'(CH_STRIDE * i + TVAL_OFS);
        localparam logic [LCSR_BIT-1:0] A_TICLR = ADDR_BASE + LCSR_BIT'(CH_STRIDE * i + TICLR_OFS);

        logic tcfg_we_s;
        logic ticlr_we_s;
        logic rd_tcfg_s;
        logic rd_tval_s;

        assign tcfg_we_s  = csr_wen && (csr_waddr == A_TCFG);
        assign ticlr_we_s = csr_wen && (csr_waddr == A_TICLR);
        assign rd_tcfg_s  = (csr_raddr == A_TCFG);
        assign rd_tval_s  = (csr_raddr == A_TVAL);

        c7bcsr_tchan #(
            .TIMER_BIT (TIMER_BIT)
        ) u_tchan (
            .clk      (clk),
            .resetn   (resetn),
            .tick     (tick_s),
            .tcfg_we  (tcfg_we_s),
            .ticlr_we (ticlr_we_s),
            .wdata    (csr_wdata),
            .mask     (csr_mask),
            .rd_tcfg  (rd_tcfg_s),
            .rd_tval  (rd_tval_s),
            .rdata    (ch_rdata_s[i]),
            .pending  (pending_s[i])
        );
    end

    // At most one channel decodes a given address, so OR-ing is a mux.
    always_comb begin
        csr_rdata = 32'd0;
        for (int k = 0; k < NCH; k++) begin
            csr_rdata = csr_rdata | ch_rdata_s[k];
        end
    end

    assign timer_intr_vec = pending_s;
    assign timer_intr     = |pending_s;

endmodule

// File: tb/tb_c7bcsr_mtimer.sv
// Directed bench for c7bcsr_mtimer: one instance with PRESCALE=1 and one with
// PRESCALE=4 share the CSR bus; expected values are hand-computed.
module tb_c7bcsr_mtimer;

    logic        clk = 1'b0;
    logic        resetn;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_mask;
    logic        csr_wen;
    logic [13:0] csr_raddr;
    logic [31:0] rdata1, rdata4;
    logic [3:0]  vec1, vec4;
    logic        intr1, intr4;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_cnt;

    always #5 clk = ~clk;

    c7bcsr_mtimer #(.NCH(4), .TIMER_BIT(30), .PRESCALE(1), .LCSR_BIT(14), .ADDR_BASE(14'h41)) dut1 (
        .clk(clk), .resetn(resetn), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .csr_mask(csr_mask), .csr_wen(csr_wen), .csr_raddr(csr_raddr),
        .csr_rdata(rdata1), .timer_intr_vec(vec1), .timer_intr(intr1));

    c7bcsr_mtimer #(.NCH(4), .TIMER_BIT(30), .PRESCALE(4), .LCSR_BIT(14), .ADDR_BASE(14'h41)) dut4 (
        .clk(clk), .resetn(resetn), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .csr_mask(csr_mask), .csr_wen(csr_wen), .csr_raddr(csr_raddr),
        .csr_rdata(rdata4), .timer_intr_vec(vec4), .timer_intr(intr4));

    // Posedges since reset release; PRESCALE=4 ticks on every edge whose index is a multiple of 4.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) edge_cnt <= 0;
        else         edge_cnt <= edge_cnt + 1;
    end

    typedef struct {
        logic [13:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        string       name;
        logic [13:0] waddr;
        logic [31:0] wdata;
        logic [31:0] wmask;
        logic [13:0] raddr;
        logic [31:0] exp;
    } cfg_vec_t;

    function automatic logic [13:0] a_tcfg(input int ch);
        return 14'(32'h41 + 32'd4 * ch);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input logic [13:0] addr, input logic [31:0] data, input logic [31:0] msk);
        csr_waddr = addr;
        csr_wdata = data;
        csr_mask  = msk;
        csr_wen   = 1'b1;
        @(negedge clk);
        csr_wen   = 1'b0;
    endtask

    task automatic rd(input logic [13:0] addr);
        csr_raddr = addr;
        #1;
    endtask

    rd_vec_t  rv [16];
    cfg_vec_t cv [7];

    initial begin
        int got_fire;
        int got_zero;
        int w_edge;
        int t1;
        logic seen;

        for (int c = 0; c < 4; c++) begin
            rv[3*c]     = '{a_tcfg(c),         32'd0};
            rv[3*c + 1] = '{a_tcfg(c) + 14'd1, 32'd0};
            rv[3*c + 2] = '{a_tcfg(c) + 14'd3, 32'd0};
        end
        rv[12] = '{14'h40, 32'd0};
        rv[13] = '{14'h44, 32'd0};
        rv[14] = '{14'h51, 32'd0};
        rv[15] = '{14'h00, 32'd0};

        cv[0] = '{"cfg_full",     14'h4D, 32'h0000_0FF0, 32'hFFFF_FFFF, 14'h4D, 32'h0000_0FF0};
        cv[1] = '{"cfg_mask_mid", 14'h4D, 32'h0000_0006, 32'h0000_000E, 14'h4D, 32'h0000_0FF6};
        cv[2] = '{"cfg_mask_top", 14'h4D, 32'hFFFF_FFFF, 32'hC000_0000, 14'h4D, 32'hC000_0FF6};
        cv[3] = '{"tval_ro",      14'h4E, 32'h0000_1234, 32'hFFFF_FFFF, 14'h4E, 32'h3000_03FD};
        cv[4] = '{"unmapped",     14'h4F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h4F, 32'h0000_0000};
        cv[5] = '{"ticlr_rd0",    14'h50, 32'h0000_0001, 32'h0000_0001, 14'h50, 32'h0000_0000};
        cv[6] = '{"cfg_kept",     14'h4F, 32'h0000_0000, 32'hFFFF_FFFF, 14'h4D, 32'hC000_0FF6};

        resetn    = 1'b0;
        csr_waddr = 14'd0;
        csr_wdata = 32'd0;
        csr_mask  = 32'd0;
        csr_wen   = 1'b0;
        csr_raddr = 14'd0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Reset state of every mapped register and a few unmapped ones.
        for (int i = 0; i < 16; i++) begin
            rd(rv[i].addr);
            chk($sformatf("reset_rd1_%0h", rv[i].addr), rdata1, rv[i].exp);
            chk($sformatf("reset_rd4_%0h", rv[i].addr), rdata4, rv[i].exp);
        end
        chk("reset_intr1", {31'd0, intr1}, 32'd0);
        chk("reset_intr4", {31'd0, intr4}, 32'd0);
        @(negedge clk);

        // Field merge / read-back table on ch3 with EN=0.
        for (int i = 0; i < 7; i++) begin
            wr(cv[i].waddr, cv[i].wdata, cv[i].wmask);
            rd(cv[i].raddr);
            chk({cv[i].name, "_1"}, rdata1, cv[i].exp);
            chk({cv[i].name, "_4"}, rdata4, cv[i].exp);
            @(negedge clk);
        end
        wr(14'h4D, 32'd0, 32'hFFFF_FFFF);

        // ch0 one-shot INITVAL=5: TVAL 5..0, fire 6 edges after the write.
        wr(14'h41, 32'h0000_0015, 32'hFFFF_FFFF);
        for (int k = 0; k < 6; k++) begin
            rd(14'h42);
            chk($sformatf("os_tval_%0d", k), rdata1, 32'(5 - k));
            chk($sformatf("os_nopend_%0d", k), {31'd0, vec1[0]}, 32'd0);
            @(negedge clk);
        end
        chk("os_fire", {31'd0, vec1[0]}, 32'd1);
        chk("os_intr", {31'd0, intr1}, 32'd1);
        wr(14'h44, 32'h0000_0001, 32'h0000_0001);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            seen = seen | vec1[0];
            @(negedge clk);
        end
        chk("os_once", {31'd0, seen}, 32'd0);
        rd(14'h42);
        chk("os_tval_hold", rdata1, 32'd0);
        @(negedge clk);

        // ch2 periodic INITVAL=2: pending every 3 edges; fire beats TICLR.
        wr(14'h49, 32'h0000_000B, 32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("per_quiet_%0d", k), {31'd0, vec1[2]}, 32'd0);
            @(negedge clk);
        end
        chk("per_fire1", {31'd0, vec1[2]}, 32'd1);
        wr(14'h4C, 32'h0000_0001, 32'h0000_0001);
        chk("per_clr", {31'd0, vec1[2]}, 32'd0);
        @(negedge clk);
        chk("per_quiet_pre", {31'd0, vec1[2]}, 32'd0);
        wr(14'h4C, 32'h0000_0001, 32'h0000_0001);
        chk("per_fire_beats_clr", {31'd0, vec1[2]}, 32'd1);
        wr(14'h4C, 32'h0000_0001, 32'h0000_0001);
        chk("per_clr2", {31'd0, vec1[2]}, 32'd0);
        wr(14'h49, 32'd0, 32'hFFFF_FFFF);

        // PRESCALE=4, ch1 one-shot INITVAL=1: decrement and fire only on ticks.
        wr(14'h45, 32'h0000_0005, 32'hFFFF_FFFF);
        w_edge   = edge_cnt;
        t1       = (w_edge / 4 + 1) * 4;
        got_fire = -1;
        got_zero = -1;
        rd(14'h46);
        chk("ps4_tval_load", rdata4, 32'd1);
        for (int k = 0; k < 16; k++) begin
            #1;
            if (got_zero < 0 && rdata4 == 32'd0) got_zero = edge_cnt;
            if (got_fire < 0 && vec4[1]) got_fire = edge_cnt;
            @(negedge clk);
        end
        chk("ps4_dec_edge", 32'(got_zero), 32'(t1));
        chk("ps4_fire_edge", 32'(got_fire), 32'(t1 + 4));
        chk("ps4_fire_window", 32'((got_fire - w_edge >= 5) && (got_fire - w_edge <= 8)), 32'd1);

        // Masked write mask=1, wdata=0 mid-count: EN off, reload and hold.
        wr(14'h41, 32'h0000_0029, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        rd(14'h42);
        chk("mask_midcount", rdata1, 32'd7);
        @(negedge clk);
        wr(14'h41, 32'h0000_0000, 32'h0000_0001);
        rd(14'h41);
        chk("mask_tcfg", rdata1, 32'h0000_0028);
        for (int k = 0; k < 10; k++) begin
            rd(14'h42);
            chk($sformatf("mask_hold_%0d", k), rdata1, 32'd10);
            @(negedge clk);
        end

        // Async reset while ch3 counts from 100; idle until TCFG rewrite.
        wr(14'h45, 32'h0000_0003, 32'hFFFF_FFFF);
        wr(14'h4D, 32'h0000_0191, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        rd(14'h4E);
        chk("rst_pre_tval", rdata1, 32'd95);
        chk("rst_pre_intr", {31'd0, intr1}, 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk("rst_async_vec1", {28'd0, vec1}, 32'd0);
        chk("rst_async_vec4", {28'd0, vec4}, 32'd0);
        chk("rst_async_intr", {30'd0, intr1, intr4}, 32'd0);
        chk("rst_async_tval", rdata1, 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 110; k++) begin
            seen = seen | (|vec1) | (|vec4);
            @(negedge clk);
        end
        chk("rst_idle", {31'd0, seen}, 32'd0);
        wr(14'h4D, 32'h0000_0005, 32'hFFFF_FFFF);
        chk("rst_rearm_0", {31'd0, vec1[3]}, 32'd0);
        @(negedge clk);
        chk("rst_rearm_1", {31'd0, vec1[3]}, 32'd0);
        @(negedge clk);
        chk("rst_rearm_fire", {31'd0, vec1[3]}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
